// File: rtl/wb_stage.sv
// Writeback stage: selects the register-file write value and owns tohost, halt and the cycle/instret CSRs.
// Optional performance counters are built when WB_PERF_CTR_EN is defined.
module wb_stage #(
    parameter logic [31:0] NOP         = 32'h0000_0013,
    parameter logic [3:0]  IO_BASE_NIB = 4'h8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] wb_alu,
    input  logic [31:0] wb_pc4,
    input  logic [31:0] wb_dmem_dout,
    input  logic [31:0] wb_io_dout,
    input  logic [31:0] wb_inst,
    output logic [31:0] wb_wdata,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] csr_tohost,
    output logic        halt
);

    localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
    localparam logic [6:0]  OPC_JAL    = 7'b1101111;
    localparam logic [6:0]  OPC_JALR   = 7'b1100111;
    localparam logic [6:0]  OPC_OP     = 7'b0110011;
    localparam logic [6:0]  OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0]  OPC_LUI    = 7'b0110111;
    localparam logic [6:0]  OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0]  OPC_SYSTEM = 7'b1110011;

    localparam logic [11:0] CSR_TOHOST  = 12'h51E;
    localparam logic [11:0] CSR_CYCLE   = 12'hC00;
    localparam logic [11:0] CSR_INSTRET = 12'hC02;

    // Extract and extend the addressed byte/half; unknown widths pass the word through.
    function automatic logic [31:0] load_unpack(input logic [31:0] word,
                                                input logic [1:0]  off,
                                                input logic [2:0]  f3);
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        logic [31:0] res_v;
        case (off)
            2'd0:    byte_v = word[7:0];
            2'd1:    byte_v = word[15:8];
            2'd2:    byte_v = word[23:16];
            2'd3:    byte_v = word[31:24];
            default: byte_v = word[7:0];
        endcase
        half_v = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  res_v = {{24{byte_v[7]}}, byte_v};
            3'b100:  res_v = {24'd0, byte_v};
            3'b001:  res_v = {{16{half_v[15]}}, half_v};
            3'b101:  res_v = {16'd0, half_v};
            default: res_v = word;
        endcase
        return res_v;
    endfunction

    logic [6:0]  opcode_s;
    logic [2:0]  funct3_s;
    logic [4:0]  rd_s;
    logic [11:0] csr_addr_s;
    logic [31:0] load_word_s;
    logic [31:0] load_val_s;
    logic [31:0] csr_rdata_s;
    logic [31:0] cycle_val_s;
    logic [31:0] instret_val_s;
    logic        tohost_we_s;
    logic [31:0] tohost_wdata_s;
    logic [31:0] tohost_r;
    logic        halt_r;

    assign opcode_s   = wb_inst[6:0];
    assign funct3_s   = wb_inst[14:12];
    assign rd_s       = wb_inst[11:7];
    assign csr_addr_s = wb_inst[31:20];
    assign rf_waddr   = rd_s;

    assign load_word_s = (wb_alu[31:28] == IO_BASE_NIB) ? wb_io_dout : wb_dmem_dout;
    assign load_val_s  = load_unpack(load_word_s, wb_alu[1:0], funct3_s);

`ifdef WB_PERF_CTR_EN
    logic [31:0] cycle_r;
    logic [31:0] instret_r;

    // Performance counters freeze once the core has halted; both wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_r   <= 32'd0;
            instret_r <= 32'd0;
        end else if (!halt_r) begin
            cycle_r <= cycle_r + 32'd1;
            if (wb_inst != NOP) begin
                instret_r <= instret_r + 32'd1;
            end
        end
    end

    assign cycle_val_s   = cycle_r;
    assign instret_val_s = instret_r;
`else
    logic unused_nop_s;
    assign unused_nop_s  = &{1'b0, NOP};
    assign cycle_val_s   = 32'd0;
    assign instret_val_s = 32'd0;
`endif

    // CSR read mux; reads always see the pre-update value.
    always_comb begin
        csr_rdata_s = 32'd0;
        case (csr_addr_s)
            CSR_TOHOST:  csr_rdata_s = tohost_r;
            CSR_CYCLE:   csr_rdata_s = cycle_val_s;
            CSR_INSTRET: csr_rdata_s = instret_val_s;
            default:     csr_rdata_s = 32'd0;
        endcase
    end

    // Only CSRRW/CSRRWI to tohost change state; set/clear forms and counter writes are ignored.
    always_comb begin
        tohost_we_s    = 1'b0;
        tohost_wdata_s = wb_alu;
        if ((opcode_s == OPC_SYSTEM) && (csr_addr_s == CSR_TOHOST)) begin
            case (funct3_s)
                3'b001: begin
                    tohost_we_s    = 1'b1;
                    tohost_wdata_s = wb_alu;
                end
                3'b101: begin
                    tohost_we_s    = 1'b1;
                    tohost_wdata_s = {27'd0, wb_inst[19:15]};
                end
                default: tohost_we_s = 1'b0;
            endcase
        end else begin
            tohost_we_s = 1'b0;
        end
    end

    // Writeback value and enable; x0 is never written.
    always_comb begin
        wb_wdata = wb_alu;
        rf_we    = 1'b0;
        case (opcode_s)
            OPC_LOAD: begin
                wb_wdata = load_val_s;
                rf_we    = 1'b1;
            end
            OPC_JAL, OPC_JALR: begin
                wb_wdata = wb_pc4;
                rf_we    = 1'b1;
            end
            OPC_OP, OPC_OPIMM, OPC_LUI, OPC_AUIPC: begin
                wb_wdata = wb_alu;
                rf_we    = 1'b1;
            end
            OPC_SYSTEM: begin
                wb_wdata = csr_rdata_s;
                rf_we    = 1'b1;
            end
            default: begin
                wb_wdata = wb_alu;
                rf_we    = 1'b0;
            end
        endcase
        if (rd_s == 5'd0) begin
            rf_we = 1'b0;
        end else begin
            rf_we = rf_we;
        end
    end

    // tohost register and sticky halt flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tohost_r <= 32'd0;
            halt_r   <= 1'b0;
        end else if (tohost_we_s) begin
            tohost_r <= tohost_wdata_s;
            if (tohost_wdata_s[0]) begin
                halt_r <= 1'b1;
            end
        end
    end

    assign csr_tohost = tohost_r;
    assign halt       = halt_r;

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage: load unpack, writeback select, CSR/tohost/halt and counters.
module tb_wb_stage;

    localparam logic [31:0] NOP       = 32'h0000_0013;
    localparam logic [31:0] I_ADDI    = 32'h0010_0093;
    localparam logic [31:0] I_SW      = 32'h0011_2023;
    localparam logic [31:0] I_LB      = 32'h0000_0283;
    localparam logic [31:0] I_LH      = 32'h0000_1283;
    localparam logic [31:0] I_LW      = 32'h0000_2283;
    localparam logic [31:0] I_LD3     = 32'h0000_3283;
    localparam logic [31:0] I_LBU     = 32'h0000_4283;
    localparam logic [31:0] I_LHU     = 32'h0000_5283;
    localparam logic [31:0] I_JAL0    = 32'h0000_006F;
    localparam logic [31:0] I_JAL1    = 32'h0000_00EF;
    localparam logic [31:0] I_CSRRW   = 32'h51E0_92F3;
    localparam logic [31:0] I_CSRRS   = 32'h51E0_A373;
    localparam logic [31:0] I_CSRRWI1 = 32'h51E0_D073;
    localparam logic [31:0] I_RD_CYC  = 32'hC000_2373;
    localparam logic [31:0] I_RD_INS  = 32'hC020_2373;
    localparam logic [31:0] I_RD_UNK  = 32'h1230_2373;

    logic        clk;
    logic        rst_n;
    logic [31:0] wb_alu;
    logic [31:0] wb_pc4;
    logic [31:0] wb_dmem_dout;
    logic [31:0] wb_io_dout;
    logic [31:0] wb_inst;
    logic [31:0] wb_wdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] csr_tohost;
    logic        halt;

    int          n_tests;
    int          n_fail;
    logic [31:0] cyc_m;
    logic [31:0] ins_m;
    logic        halt_m;
    logic [31:0] prog [8];

    wb_stage #(.NOP(NOP), .IO_BASE_NIB(4'h8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wb_alu       (wb_alu),
        .wb_pc4       (wb_pc4),
        .wb_dmem_dout (wb_dmem_dout),
        .wb_io_dout   (wb_io_dout),
        .wb_inst      (wb_inst),
        .wb_wdata     (wb_wdata),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .csr_tohost   (csr_tohost),
        .halt         (halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic drv(input logic [31:0] inst, input logic [31:0] alu);
        wb_inst = inst;
        wb_alu  = alu;
        #1;
    endtask

    // One retiring cycle; the counter model mirrors the architectural rule, not the RTL.
    task automatic step();
        @(posedge clk);
        if (!halt_m) begin
            cyc_m = cyc_m + 32'd1;
            if (wb_inst !== NOP) ins_m = ins_m + 32'd1;
        end
        #1;
    endtask

    function automatic logic [31:0] ctr_exp(input logic [31:0] v);
`ifdef WB_PERF_CTR_EN
        return v;
`else
        return 32'd0 & v;
`endif
    endfunction

    initial begin
        n_tests = 0;
        n_fail  = 0;
        cyc_m   = 32'd0;
        ins_m   = 32'd0;
        halt_m  = 1'b0;
        rst_n   = 1'b0;
        wb_inst = NOP;
        wb_alu  = 32'd0;
        wb_pc4  = 32'h0000_1004;
        wb_dmem_dout = 32'h8899_AABB;
        wb_io_dout   = 32'h0000_005A;
        prog[0] = I_ADDI; prog[1] = NOP;    prog[2] = I_SW;   prog[3] = NOP;
        prog[4] = I_JAL1; prog[5] = I_ADDI; prog[6] = NOP;    prog[7] = I_LW;

        #2;
        check_eq("rst_tohost", csr_tohost, 32'd0);
        check_eq("rst_halt", {31'd0, halt}, 32'd0);
        check_eq("rst_rf_we", {31'd0, rf_we}, 32'd0);
        repeat (2) @(negedge clk);

        // 5 non-NOP + 3 NOP over the first 8 edges after release
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drv(prog[i], 32'h0000_0100);
            step();
        end
        drv(I_RD_INS, 32'd0);
        check_eq("instret_8cyc", wb_wdata, ctr_exp(32'd5));
        check_eq("csrr_we", {31'd0, rf_we}, 32'd1);
        check_eq("csrr_waddr", {27'd0, rf_waddr}, 32'd6);
        step();
        drv(I_RD_CYC, 32'd0);
        check_eq("cycle_9cyc", wb_wdata, ctr_exp(32'd9));
        step();

        drv(I_LB, 32'h0000_0102);
        check_eq("lb", wb_wdata, 32'hFFFF_FF99);
        check_eq("lb_we", {31'd0, rf_we}, 32'd1);
        drv(I_LBU, 32'h0000_0102);
        check_eq("lbu", wb_wdata, 32'h0000_0099);
        drv(I_LBU, 32'h0000_0103);
        check_eq("lbu_b3", wb_wdata, 32'h0000_0088);
        drv(I_LH, 32'h0000_0102);
        check_eq("lh", wb_wdata, 32'hFFFF_8899);
        check_eq("lh_we", {31'd0, rf_we}, 32'd1);
        drv(I_LHU, 32'h0000_0001);
        check_eq("lhu_lo", wb_wdata, 32'h0000_AABB);
        drv(I_LW, 32'h8000_0008);
        check_eq("lw_io", wb_wdata, 32'h0000_005A);
        drv(I_LW, 32'h0000_0103);
        check_eq("lw_dmem", wb_wdata, 32'h8899_AABB);
        drv(I_LD3, 32'h0000_0102);
        check_eq("ld_f3_011", wb_wdata, 32'h8899_AABB);
        drv(I_JAL1, 32'h0000_0040);
        check_eq("jal_wdata", wb_wdata, 32'h0000_1004);
        check_eq("jal_we", {31'd0, rf_we}, 32'd1);
        drv(I_SW, 32'h0000_0040);
        check_eq("sw_we", {31'd0, rf_we}, 32'd0);
        check_eq("sw_wdata", wb_wdata, 32'h0000_0040);
        drv(I_ADDI, 32'h0000_0077);
        check_eq("addi_wdata", wb_wdata, 32'h0000_0077);
        step();

        drv(I_CSRRW, 32'h0000_1234);
        check_eq("csrrw_old", wb_wdata, 32'd0);
        step();
        check_eq("tohost_w", csr_tohost, 32'h0000_1234);
        check_eq("halt_after_w", {31'd0, halt}, 32'd0);
        drv(I_CSRRS, 32'h0000_FFFF);
        check_eq("csrrs_rd", wb_wdata, 32'h0000_1234);
        step();
        check_eq("csrrs_nochg", csr_tohost, 32'h0000_1234);
        drv(I_RD_UNK, 32'd0);
        check_eq("csr_unknown", wb_wdata, 32'd0);
        step();
        drv(I_RD_CYC, 32'd0);
        check_eq("cycle_prehalt", wb_wdata, ctr_exp(cyc_m));
        step();

        drv(I_CSRRWI1, 32'hFFFF_FFFF);
        check_eq("csrrwi_old", wb_wdata, 32'h0000_1234);
        check_eq("csrrwi_x0_we", {31'd0, rf_we}, 32'd0);
        step();
        halt_m = 1'b1;
        check_eq("halt_set", {31'd0, halt}, 32'd1);
        check_eq("tohost_imm", csr_tohost, 32'd1);
        for (int i = 0; i < 10; i++) begin
            drv(I_ADDI, 32'd0);
            step();
        end
        drv(I_RD_CYC, 32'd0);
        check_eq("cycle_frozen", wb_wdata, ctr_exp(cyc_m));
        step();
        drv(I_RD_INS, 32'd0);
        check_eq("instret_frozen", wb_wdata, ctr_exp(ins_m));
        step();
        drv(I_CSRRW, 32'h0000_1234);
        step();
        check_eq("tohost_after_halt", csr_tohost, 32'h0000_1234);
        check_eq("halt_sticky", {31'd0, halt}, 32'd1);

        // asynchronous reset mid-cycle, with a tohost write pending
        drv(I_CSRRW, 32'h0000_5555);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("arst_tohost", csr_tohost, 32'd0);
        check_eq("arst_halt", {31'd0, halt}, 32'd0);
        drv(I_RD_CYC, 32'd0);
        check_eq("arst_cycle", wb_wdata, 32'd0);
        drv(I_JAL0, 32'd0);
        check_eq("jal_x0_we", {31'd0, rf_we}, 32'd0);
        wb_inst = NOP;
        cyc_m  = 32'd0;
        ins_m  = 32'd0;
        halt_m = 1'b0;
        @(posedge clk);
        #1;
        check_eq("arst_hold_tohost", csr_tohost, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drv(I_RD_CYC, 32'd0);
        check_eq("cycle_first", wb_wdata, ctr_exp(32'd0));
        step();
        drv(I_RD_CYC, 32'd0);
        check_eq("cycle_second", wb_wdata, ctr_exp(32'd1));
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
